mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_arb_pkg.sv | 16 +
 rtl/rr_pick4.sv | 25 ++
 rtl/mux_rr_arbiter.sv | 96 +++++++++
 tb/tb_mux_rr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared sizing and state encoding for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned W     = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin winner search over four requests, starting just after `last`.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       any,
  output logic [1:0] win
);

  logic [1:0] idx;

  always_comb begin
    any = 1'b0;
    win = 2'd0;
    idx = 2'd0;
    // Offsets 1..4 wrap mod 4, so `last` itself is visited last.
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin arbiter feeding a one-entry registered output stage.
module mux_rr_arbiter #(
  parameter int unsigned N_REQ = mux_arb_pkg::N_REQ,
  parameter int unsigned W     = mux_arb_pkg::W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_sel
);

  import mux_arb_pkg::arb_state_e;
  import mux_arb_pkg::EMPTY;
  import mux_arb_pkg::FULL;
  import mux_arb_pkg::idx_to_onehot;

  arb_state_e state_q, state_d;
  logic [1:0]   last_q, last_d;
  logic [1:0]   sel_q, sel_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] pick_data;
  logic [1:0]   win;
  logic         any;
  logic         load;
  logic         grant;

  rr_pick4 u_pick (
    .req  (req_valid),
    .last (last_q),
    .any  (any),
    .win  (win)
  );

  // Only the winner's word is routed, so X on a losing input never reaches the register.
  always_comb begin
    pick_data = '0;
    case (win)
      2'd0:    pick_data = d0;
      2'd1:    pick_data = d1;
      2'd2:    pick_data = d2;
      2'd3:    pick_data = d3;
      default: pick_data = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    data_d    = data_q;
    req_ready = '0;
    load      = (state_q == EMPTY) || out_ready;
    grant     = load && any;

    // rst_n gates the handshake so nothing is accepted while reset is held.
    if (grant && rst_n) begin
      req_ready = idx_to_onehot(win);
    end

    if (grant) begin
      state_d = FULL;
      data_d  = pick_data;
      sel_d   = win;
      last_d  = win;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with an in-order scoreboard run on every clock step.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [3:0] d0, d1, d2, d3;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_sel;

  int errors = 0;
  int checks = 0;
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .N_REQ (4),
    .W     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  // One clock step; records input/output handshakes just before the edge.
  task automatic tick;
    logic       in_hs;
    logic [3:0] in_word;
    logic       out_hs;
    logic [3:0] out_word;
    logic [3:0] exp_word;
    #1;
    in_hs   = 1'b0;
    in_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] === 1'b1 && req_ready[i] === 1'b1) begin
        in_hs = 1'b1;
        case (i)
          0:       in_word = d0;
          1:       in_word = d1;
          2:       in_word = d2;
          default: in_word = d3;
        endcase
      end
    end
    out_hs   = (out_valid === 1'b1) && (out_ready === 1'b1);
    out_word = out_data;
    @(posedge clk);
    if (out_hs) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_order: output word %h delivered but none pending", out_word);
      end else begin
        exp_word = sb_q.pop_front();
        if (out_word !== exp_word) begin
          errors++;
          $display("FAIL sb_order: delivered %h, required %h", out_word, exp_word);
        end
      end
    end
    if (in_hs) sb_q.push_back(in_word);
    #1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 4'h0 || out_sel !== 2'd0) begin
      errors++; $display("FAIL rst_data: got %h/%0d want 0/0", out_data, out_sel);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL rst_ready: got %b want 0000", req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_first_prio: got %b want 0001", req_ready);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] vals[4];
    logic [3:0] exp_rdy;
    logic [3:0] one;
    vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC; vals[3] = 4'hD;
    one = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_rdy = one << ((k + 1) % 4);
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== vals[k % 4]) begin
        errors++;
        $display("FAIL rr_out[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                 k, out_valid, out_sel, out_data, k % 4, vals[k % 4]);
      end
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy);
      end
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'hA || out_sel !== 2'd0) begin
      errors++;
      $display("FAIL rr_drain: got v=%b data=%h sel=%0d want v=0 data=a sel=0",
               out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_hold;
    req_valid = 4'b0100;
    d2        = 4'd7;
    out_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL hold_load_empty: got %b want 0100", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd7 || out_sel !== 2'd2) begin
      errors++;
      $display("FAIL hold_capture: got v=%b data=%h sel=%0d want 1/7/2", out_valid, out_data, out_sel);
    end
    d2 = 4'd9;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'd7 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL hold_stall[%0d]: got v=%b data=%h rdy=%b want 1/7/0000",
                 k, out_valid, out_data, req_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL hold_release_ready: got %b want 0100", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'd9) begin
      errors++; $display("FAIL hold_reload: got v=%b data=%h want 1/9", out_valid, out_data);
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'd9) begin
      errors++; $display("FAIL hold_empty: got v=%b data=%h want 0/9", out_valid, out_data);
    end
  endtask

  task automatic test_last_one;
    req_valid = 4'b0010;
    d1        = 4'd1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_sel !== 2'd1) begin
      errors++; $display("FAIL last1_setup: got sel=%0d want 1", out_sel);
    end
    req_valid = 4'b1001;
    d0 = 4'd4;
    d3 = 4'd3;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL last1_ready: got %b want 1000", req_ready);
    end
    tick();
    checks++;
    if (out_sel !== 2'd3 || out_data !== 4'd3) begin
      errors++; $display("FAIL last1_win3: got sel=%0d data=%h want 3/3", out_sel, out_data);
    end
    tick();
    checks++;
    if (out_sel !== 2'd0 || out_data !== 4'd4) begin
      errors++; $display("FAIL last1_win0: got sel=%0d data=%h want 0/4", out_sel, out_data);
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL last1_empty: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_x_input;
    d3        = 4'bxxxx;
    d0        = 4'd5;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL xin_ready: got %b want 0001", req_ready);
    end
    tick();
    checks++;
    if (out_data !== 4'd5 || out_sel !== 2'd0) begin
      errors++; $display("FAIL xin_data: got data=%h sel=%0d want 5/0", out_data, out_sel);
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'd5) begin
      errors++; $display("FAIL xin_hold: got v=%b data=%h want 0/5", out_valid, out_data);
    end
    d3 = 4'd0;
  endtask

  task automatic test_async_reset;
    req_valid = 4'b0100;
    d2        = 4'd6;
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2) begin
      errors++; $display("FAIL arst_setup: got v=%b sel=%0d want 1/2", out_valid, out_sel);
    end
    req_valid = 4'b1111;
    d0 = 4'd8; d1 = 4'd1; d2 = 4'd2; d3 = 4'd3;
    #3;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'd0 || out_sel !== 2'd0) begin
      errors++;
      $display("FAIL arst_drop: got v=%b data=%h sel=%0d want 0/0/0", out_valid, out_data, out_sel);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL arst_ready: got %b want 0000", req_ready);
    end
    out_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL arst_prio: got %b want 0001", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'd8) begin
      errors++;
      $display("FAIL arst_grant: got v=%b sel=%0d data=%h want 1/0/8", out_valid, out_sel, out_data);
    end
    req_valid = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL arst_empty: got v=%b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_last_one();
    test_x_input();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
